// File: rtl/window_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : window_framer_pkg
//  Description : Shared constants and state encoding for the window framer:
//                default settings-bus addresses, register widths and the
//                KEEP/DROP frame state.
//  Revision    : 1.0 - initial release
// ============================================================================
package window_framer_pkg;

    // Default settings-bus addresses
    localparam int C_SR_FRAME_SIZE          = 0;
    localparam int C_SR_FRAME_DECIM         = 1;

    // Frame length register is C_MAX_LOG2_OF_FRAME_SIZE+1 bits wide so that
    // the full power-of-two length itself can be represented.
    localparam int C_MAX_LOG2_OF_FRAME_SIZE = 10;
    localparam int C_DECIM_WIDTH            = 16;

    // Frame state: KEEP forwards the frame downstream, DROP discards it.
    typedef enum logic [0:0] {
        ST_KEEP = 1'b0,
        ST_DROP = 1'b1
    } frame_state_t;

endpackage : window_framer_pkg
`default_nettype wire

// File: rtl/axi_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_out_reg
//  Description : One-entry output register for an AXI-stream style
//                data/last/valid channel. A new beat may be loaded whenever
//                the register is empty or its current beat is being taken.
//  Ports       : clk, rst, clr   - clock, reset, flush (both sync, active-high)
//                load            - write load_data/load_last this cycle
//                load_data/last  - beat to store
//                can_load        - register can accept a beat this cycle
//                tdata/tlast     - registered beat
//                tvalid, tready  - downstream handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             can_load,
    output logic [WIDTH-1:0] tdata,
    output logic             tlast,
    output logic             tvalid,
    input  logic             tready
);

    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic             r_valid;

    assign can_load = !r_valid || tready;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= load_data;
            r_last  <= load_last;
            r_valid <= 1'b1;
        end else if (tready) begin
            // Beat consumed and nothing new arriving; data/last keep their
            // old value, only valid falls.
            r_valid <= 1'b0;
        end
    end

    assign tdata  = r_data;
    assign tlast  = r_last;
    assign tvalid = r_valid;

endmodule : axi_out_reg
`default_nettype wire

// File: rtl/setting_reg.sv
`default_nettype none
// ============================================================================
//  Module      : setting_reg
//  Description : Single settings-bus register. Captures the low WIDTH bits of
//                data_in when strobe is high and addr matches MY_ADDR.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                strobe, addr    - settings bus strobe and address
//                data_in         - settings bus data
//                data_out        - current register value
//  Revision    : 1.0 - initial release
// ============================================================================
module setting_reg #(
    parameter int               MY_ADDR  = 0,
    parameter int               AWIDTH   = 8,
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] AT_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strobe,
    input  logic [AWIDTH-1:0] addr,
    input  logic [31:0]       data_in,
    output logic [WIDTH-1:0]  data_out
);

    logic [WIDTH-1:0] r_value;

    // Only the low WIDTH bits are stored; the rest of the bus word is ignored.
    logic w_unused_bits;
    assign w_unused_bits = ^data_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= AT_RESET;
        end else if (strobe && (addr == AWIDTH'(MY_ADDR))) begin
            r_value <= data_in[WIDTH-1:0];
        end
    end

    assign data_out = r_value;

endmodule : setting_reg
`default_nettype wire

// File: rtl/window_framer.sv
`default_nettype none
// ============================================================================
//  Module      : window_framer
//  Description : Cuts a continuous sample stream into frames of programmable
//                length L and forwards one frame in every D+1, marking the
//                last sample of each forwarded frame with o_tlast. L and D
//                are written over the settings bus and only take effect at
//                frame boundaries (shadow copies reload on the last sample).
//  Ports       : clk, reset, clear        - clock, sync resets (active-high)
//                set_stb/addr/data        - settings bus
//                i_tdata/tlast/tvalid/tready - input stream (i_tlast ignored)
//                o_tdata/tlast/tvalid/tready - framed output stream
//                frames_dropped           - wrapping count of dropped frames
//  Revision    : 1.0 - initial release
// ============================================================================
module window_framer
    import window_framer_pkg::*;
#(
    parameter int SR_FRAME_SIZE          = C_SR_FRAME_SIZE,
    parameter int SR_FRAME_DECIM         = C_SR_FRAME_DECIM,
    parameter int MAX_LOG2_OF_FRAME_SIZE = C_MAX_LOG2_OF_FRAME_SIZE,
    parameter int WIDTH                  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [31:0]      frames_dropped
);

    localparam int               C_LW      = MAX_LOG2_OF_FRAME_SIZE + 1;
    localparam int               C_DW      = C_DECIM_WIDTH;
    localparam logic [C_LW-1:0]  C_L_RESET = {1'b1, {MAX_LOG2_OF_FRAME_SIZE{1'b0}}};

    // ------------------------------------------------------------------
    // Settings registers
    // ------------------------------------------------------------------
    logic [C_LW-1:0] w_frame_size_reg;
    logic [C_DW-1:0] w_decim_reg;

    setting_reg #(
        .MY_ADDR  (SR_FRAME_SIZE),
        .AWIDTH   (8),
        .WIDTH    (C_LW),
        .AT_RESET (C_L_RESET)
    ) u_sr_frame_size (
        .clk      (clk),
        .rst      (reset),
        .strobe   (set_stb),
        .addr     (set_addr),
        .data_in  (set_data),
        .data_out (w_frame_size_reg)
    );

    setting_reg #(
        .MY_ADDR  (SR_FRAME_DECIM),
        .AWIDTH   (8),
        .WIDTH    (C_DW),
        .AT_RESET ('0)
    ) u_sr_frame_decim (
        .clk      (clk),
        .rst      (reset),
        .strobe   (set_stb),
        .addr     (set_addr),
        .data_in  (set_data),
        .data_out (w_decim_reg)
    );

    // Value each register will hold after this cycle. Shadows load from
    // these so a write coinciding with the end of a frame applies to the
    // very next frame.
    logic            w_frame_size_wr;
    logic            w_decim_wr;
    logic [C_LW-1:0] w_frame_size_nxt;
    logic [C_DW-1:0] w_decim_nxt;

    assign w_frame_size_wr  = set_stb && (set_addr == 8'(SR_FRAME_SIZE));
    assign w_decim_wr       = set_stb && (set_addr == 8'(SR_FRAME_DECIM));
    assign w_frame_size_nxt = w_frame_size_wr ? set_data[C_LW-1:0] : w_frame_size_reg;
    assign w_decim_nxt      = w_decim_wr      ? set_data[C_DW-1:0] : w_decim_reg;

    // ------------------------------------------------------------------
    // Framing state
    // ------------------------------------------------------------------
    logic [C_LW-1:0] r_l_act;
    logic [C_DW-1:0] r_d_act;
    logic [C_LW-1:0] r_samp_cnt;
    logic [C_DW-1:0] r_frm_cnt;
    frame_state_t    r_state;
    logic [31:0]     r_frames_dropped;

    logic [C_LW-1:0] w_samp_nxt;
    logic [C_DW-1:0] w_frm_nxt;
    frame_state_t    w_state_nxt;
    logic [C_LW-1:0] w_last_idx;
    logic            w_is_last;
    logic            w_accept;
    logic            w_frame_end;
    logic            w_out_can_load;
    logic            w_load_out;

    logic w_unused_tlast;
    assign w_unused_tlast = i_tlast;

    // A programmed length of 0 behaves as a length of 1.
    assign w_last_idx  = (r_l_act == '0) ? '0 : (r_l_act - C_LW'(1));
    assign w_is_last   = (r_samp_cnt == w_last_idx);

    // Dropped frames never stall the input, even when a kept sample is
    // still waiting in the output register.
    assign i_tready    = (r_state == ST_DROP) ? 1'b1 : w_out_can_load;
    assign w_accept    = i_tvalid && i_tready;
    assign w_frame_end = w_accept && w_is_last;
    assign w_load_out  = w_accept && (r_state == ST_KEEP);

    always_comb begin
        w_samp_nxt  = r_samp_cnt;
        w_frm_nxt   = r_frm_cnt;
        w_state_nxt = r_state;
        if (w_accept) begin
            if (w_is_last) begin
                w_samp_nxt = '0;
                // >= rather than == : a shrinking reload may leave the frame
                // counter above the new decimation value.
                if (r_frm_cnt >= r_d_act) begin
                    w_frm_nxt = '0;
                end else begin
                    w_frm_nxt = r_frm_cnt + C_DW'(1);
                end
                w_state_nxt = (w_frm_nxt == '0) ? ST_KEEP : ST_DROP;
            end else begin
                w_samp_nxt = r_samp_cnt + C_LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_samp_cnt <= '0;
            r_frm_cnt  <= '0;
            r_state    <= ST_KEEP;
            // On reset the settings registers are themselves returning to
            // their defaults, so load those defaults directly.
            r_l_act    <= reset ? C_L_RESET : w_frame_size_nxt;
            r_d_act    <= reset ? '0        : w_decim_nxt;
        end else begin
            r_samp_cnt <= w_samp_nxt;
            r_frm_cnt  <= w_frm_nxt;
            r_state    <= w_state_nxt;
            if (w_frame_end) begin
                r_l_act <= w_frame_size_nxt;
                r_d_act <= w_decim_nxt;
            end
        end
    end

    // Drop counter survives clear; only reset zeroes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frames_dropped <= '0;
        end else if (!clear && w_frame_end && (r_state == ST_DROP)) begin
            r_frames_dropped <= r_frames_dropped + 32'd1;
        end
    end

    assign frames_dropped = r_frames_dropped;

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    axi_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (reset),
        .clr       (clear),
        .load      (w_load_out),
        .load_data (i_tdata),
        .load_last (w_is_last),
        .can_load  (w_out_can_load),
        .tdata     (o_tdata),
        .tlast     (o_tlast),
        .tvalid    (o_tvalid),
        .tready    (o_tready)
    );

endmodule : window_framer
`default_nettype wire
